// File: rtl/me_pkg.sv
// Shared geometry constants and scan-position helpers for the motion-estimation sequencer.
package me_pkg;
    localparam int NPE      = 16;
    localparam int REF_DIM  = 16;
    localparam int SRCH_DIM = 32;
    localparam int CNT_W    = 12;
    localparam int ADDR_R_W = 8;
    localparam int ADDR_S_W = 10;

    localparam logic [CNT_W-1:0] TERMINAL = 12'hFFF;

    typedef struct packed {
        logic [3:0] voff;
        logic [3:0] row;
        logic [3:0] col;
    } scan_pos_t;

    // Search-window row is the reference row shifted down by the vertical offset (0..30).
    function automatic logic [4:0] srch_row(input scan_pos_t p);
        return {1'b0, p.voff} + {1'b0, p.row};
    endfunction
endpackage

// File: rtl/me_scan_counter.sv
// Scan counter and busy flag; with CONTROL_DONE_PULSE_EN a one-cycle done pulse follows a full scan.
// Start restarts from 0 at any time; reset has priority over start.
module me_scan_counter
    import me_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
`ifdef CONTROL_DONE_PULSE_EN
    output logic             done_o,
`endif
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;

    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        if (start_i) begin
            count_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q == TERMINAL) begin
                count_d = '0;
                busy_d  = 1'b0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CONTROL_DONE_PULSE_EN
    logic done_q, done_d;

    // A restart landing on the terminal cycle suppresses the pulse.
    assign done_d = busy_q && (count_q == TERMINAL) && !start_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
`endif

    assign count_o = count_q;
endmodule

// File: rtl/me_control.sv
// Full-search block-matching sequencer: decodes the scan counter into memory addresses and PE controls.
// Optional macro CONTROL_DONE_PULSE_EN adds a registered end-of-scan done pulse.
module me_control
    import me_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef CONTROL_DONE_PULSE_EN
    output logic                done,
`endif
    output logic [CNT_W-1:0]    count,
    output logic [ADDR_R_W-1:0] AddressR,
    output logic [ADDR_S_W-1:0] AddressS1,
    output logic [ADDR_S_W-1:0] AddressS2,
    output logic [NPE-1:0]      S1S2mux,
    output logic [NPE-1:0]      newdist,
    output logic [NPE-1:0]      peready,
    output logic                compstart,
    output logic [3:0]          vectorX,
    output logic [3:0]          vectorY
);
    scan_pos_t  pos;
    logic [4:0] row;

    me_scan_counter u_scan_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
`ifdef CONTROL_DONE_PULSE_EN
        .done_o  (done),
`endif
        .count_o (count)
    );

    assign pos       = scan_pos_t'(count);
    assign row       = srch_row(pos);
    assign AddressR  = {pos.row, pos.col};
    assign AddressS1 = {row, 1'b0, pos.col};
    assign AddressS2 = {row, 1'b1, pos.col};

    // Any nonzero vertical offset means count >= 256: the previous offset's sums are complete.
    assign compstart = (pos.voff != 4'd0);

    // The comparator registers its inputs, so the reported vector lags the scan by one.
    assign vectorX = pos.col  - 4'd1;
    assign vectorY = pos.voff - 4'd1;

    for (genvar i = 0; i < NPE; i++) begin : g_pe
        assign S1S2mux[i] = (pos.col >= 4'(i));
        assign newdist[i] = ({pos.row, pos.col} == 8'(i));
        assign peready[i] = newdist[i] && compstart;
    end
endmodule

// File: tb/tb_me_control.sv
// Directed table-driven bench for me_control plus hand-written restart/reset/terminal sequences.
module tb_me_control;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] count;
    logic [7:0]  AddressR;
    logic [9:0]  AddressS1, AddressS2;
    logic [15:0] S1S2mux, newdist, peready;
    logic        compstart;
    logic [3:0]  vectorX, vectorY;
`ifdef CONTROL_DONE_PULSE_EN
    logic        done;
`endif

    int tests  = 0;
    int failed = 0;
    int cur    = 0;

    always #5 clk = ~clk;

    me_control dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef CONTROL_DONE_PULSE_EN
        .done      (done),
`endif
        .count     (count),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .S1S2mux   (S1S2mux),
        .newdist   (newdist),
        .peready   (peready),
        .compstart (compstart),
        .vectorX   (vectorX),
        .vectorY   (vectorY)
    );

    typedef struct {
        int          cnt;
        logic [7:0]  ar;
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic [15:0] mux;
        logic [15:0] nd;
        logic [15:0] pr;
        logic        cs;
        logic [3:0]  vx;
        logic [3:0]  vy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        cur = 0;
    endtask

    initial begin
        //           cnt   AR   S1   S2   mux       nd        pr        cs  vx  vy
        vecs[0] = '{    0,   0,   0,  16, 16'h0001, 16'h0001, 16'h0000, 0, 15, 15};
        vecs[1] = '{   15,  15,  15,  31, 16'hFFFF, 16'h8000, 16'h0000, 0, 14, 15};
        vecs[2] = '{   18,  18,  34,  50, 16'h0007, 16'h0000, 16'h0000, 0,  1, 15};
        vecs[3] = '{  255, 255, 495, 511, 16'hFFFF, 16'h0000, 16'h0000, 0, 14, 15};
        vecs[4] = '{  256,   0,  32,  48, 16'h0001, 16'h0001, 16'h0001, 1, 15,  0};
        vecs[5] = '{  257,   1,  33,  49, 16'h0003, 16'h0002, 16'h0002, 1,  0,  0};
        vecs[6] = '{ 1447, 167, 487, 503, 16'h00FF, 16'h0000, 16'h0000, 1,  6,  4};
        vecs[7] = '{ 2575,  15, 335, 351, 16'hFFFF, 16'h8000, 16'h8000, 1, 14,  9};
        vecs[8] = '{ 4095, 255, 975, 991, 16'hFFFF, 16'h0000, 16'h0000, 1, 14, 14};

        reset = 1'b1;
        start = 1'b0;
        step(2);
        reset = 1'b0;

        // Idle after reset
        step(20);
        chk("idle_count", count, 0);
        chk("idle_peready", peready, 0);
        chk("idle_compstart", compstart, 0);
        chk("idle_AddressS2", AddressS2, 16);
        chk("idle_mux", S1S2mux, 16'h0001);
        chk("idle_vx", vectorX, 15);
        chk("idle_vy", vectorY, 15);
`ifdef CONTROL_DONE_PULSE_EN
        chk("idle_done", done, 0);
`endif

        // Full scan through the vector table
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].cnt - cur);
            cur = vecs[i].cnt;
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_AddressR", i), AddressR, vecs[i].ar);
            chk($sformatf("v%0d_AddressS1", i), AddressS1, vecs[i].s1);
            chk($sformatf("v%0d_AddressS2", i), AddressS2, vecs[i].s2);
            chk($sformatf("v%0d_S1S2mux", i), S1S2mux, vecs[i].mux);
            chk($sformatf("v%0d_newdist", i), newdist, vecs[i].nd);
            chk($sformatf("v%0d_peready", i), peready, vecs[i].pr);
            chk($sformatf("v%0d_compstart", i), compstart, vecs[i].cs);
            chk($sformatf("v%0d_vectorX", i), vectorX, vecs[i].vx);
            chk($sformatf("v%0d_vectorY", i), vectorY, vecs[i].vy);
`ifdef CONTROL_DONE_PULSE_EN
            chk($sformatf("v%0d_done", i), done, 0);
`endif
        end

        // Terminal wrap, then stays idle
        step(1);
        chk("wrap_count", count, 0);
`ifdef CONTROL_DONE_PULSE_EN
        chk("wrap_done", done, 1);
`endif
        step(1);
        chk("post_wrap_count", count, 0);
`ifdef CONTROL_DONE_PULSE_EN
        chk("post_wrap_done", done, 0);
`endif
        step(10);
        chk("after_scan_idle", count, 0);

        // Restart mid-scan
        pulse_start();
        step(600);
        chk("pre_restart_count", count, 600);
        pulse_start();
        chk("restart_count", count, 0);
        step(5);
        chk("restart_progress", count, 5);
        chk("restart_AddressR", AddressR, 5);

        // Reset mid-scan
        step(995);
        chk("pre_reset_count", count, 1000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("reset_count", count, 0);
        step(10);
        chk("reset_hold_count", count, 0);
        chk("reset_hold_compstart", compstart, 0);

`ifdef CONTROL_DONE_PULSE_EN
        // Restart on the terminal cycle must not produce done
        pulse_start();
        step(4095);
        chk("abort_pre_count", count, 4095);
        pulse_start();
        chk("abort_count", count, 0);
        chk("abort_done", done, 0);
        step(1);
        chk("abort_continue", count, 1);
        chk("abort_done_late", done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
